// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game encodings and line-clear points table
package tetris_pkg;

    localparam logic [5:0] GS_RESET = 6'd1;

    // Base points for a single lock; 5..7 rows score as a tetris, 0 rows score nothing
    function automatic logic [10:0] lines_to_points(input logic [2:0] n);
        logic [10:0] pts;
        case (n)
            3'd0:    pts = 11'd0;
            3'd1:    pts = 11'd40;
            3'd2:    pts = 11'd100;
            3'd3:    pts = 11'd300;
            default: pts = 11'd1200;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - score hand-off to the binary-to-BCD converter
interface score_keeper_if;
    logic [23:0] score;
    logic        conv_start;
    logic        conv_busy;

    modport master (output score, output conv_start, input conv_busy);
    modport slave  (input score, input conv_start, output conv_busy);
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - score, lines and level accumulator feeding the BCD converter
module score_keeper
    import tetris_pkg::*;
#(
    parameter int SCORE_MAX     = 9_999_999,
    parameter int LINES_PER_LVL = 10,
    parameter int LEVEL_MAX     = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [5:0]            game_state,
    input  logic                  lines_valid,
    input  logic [2:0]            lines_cleared,
    input  logic                  soft_drop,
    output logic [3:0]            level,
    output logic [15:0]           lines_total,
    output logic                  lines_overflow,
    score_keeper_if.master        conv
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_ACCUM,
        ST_NOTIFY,
        ST_WAIT_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] base_q, base_d;
    logic [4:0]  mult_q, mult_d;
    logic [14:0] product_q, product_d;
    logic [2:0]  iter_q, iter_d;
    logic [2:0]  evt_n_q, evt_n_d;
    logic        pend_valid_q, pend_valid_d;
    logic [2:0]  pend_n_q, pend_n_d;
    logic [7:0]  drop_acc_q, drop_acc_d;
    logic [3:0]  lines_to_next_q, lines_to_next_d;
    logic        busy_low_q, busy_low_d;
    logic [23:0] score_q, score_d;
    logic        conv_start_q, conv_start_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] lines_total_q, lines_total_d;
    logic        overflow_q, overflow_d;

    logic        clear;
    logic        new_evt;
    logic [2:0]  new_n;
    logic        take_evt;
    logic [2:0]  take_n;
    logic [24:0] score_sum;
    logic [16:0] lines_sum;
    logic [3:0]  ltn_sum;

    assign clear = !rst_n_in || (game_state == GS_RESET);

    // Next-state: event capture, shift-add multiply, accumulate, converter handshake
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        mult_d          = mult_q;
        product_d       = product_q;
        iter_d          = iter_q;
        evt_n_d         = evt_n_q;
        pend_valid_d    = pend_valid_q;
        pend_n_d        = pend_n_q;
        drop_acc_d      = drop_acc_q;
        lines_to_next_d = lines_to_next_q;
        busy_low_d      = busy_low_q;
        score_d         = score_q;
        conv_start_d    = 1'b0;
        level_d         = level_q;
        lines_total_d   = lines_total_q;
        overflow_d      = overflow_q;
        take_evt        = 1'b0;
        take_n          = 3'd0;
        score_sum       = 25'd0;
        lines_sum       = 17'd0;
        ltn_sum         = 4'd0;

        new_n   = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        new_evt = lines_valid && (lines_cleared != 3'd0);

        if (soft_drop && (drop_acc_q != 8'hFF)) begin
            drop_acc_d = drop_acc_q + 8'd1;
        end

        // Only IDLE consumes events; the older pending one always goes first
        if (state_q == ST_IDLE) begin
            if (pend_valid_q) begin
                take_evt     = 1'b1;
                take_n       = pend_n_q;
                pend_valid_d = new_evt;
                pend_n_d     = new_evt ? new_n : pend_n_q;
            end else if (new_evt) begin
                take_evt = 1'b1;
                take_n   = new_n;
            end
        end else if (new_evt) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_n_d     = new_n;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (take_evt) begin
                    base_d    = lines_to_points(take_n);
                    mult_d    = {1'b0, level_q} + 5'd1;
                    product_d = 15'd0;
                    iter_d    = 3'd0;
                    evt_n_d   = take_n;
                    state_d   = ST_MULT;
                end else if (drop_acc_q != 8'd0) begin
                    product_d = 15'd0;
                    evt_n_d   = 3'd0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_MULT: begin
                if (mult_q[iter_q]) begin
                    product_d = product_q + (15'(base_q) << iter_q);
                end
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd4) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                score_sum  = {1'b0, score_q} + 25'(product_q) + 25'(drop_acc_q);
                score_d    = (score_sum > 25'(SCORE_MAX)) ? 24'(SCORE_MAX) : score_sum[23:0];
                drop_acc_d = soft_drop ? 8'd1 : 8'd0;
                if (evt_n_q != 3'd0) begin
                    lines_sum     = {1'b0, lines_total_q} + 17'(evt_n_q);
                    lines_total_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                    ltn_sum       = lines_to_next_q + {1'b0, evt_n_q};
                    if (ltn_sum >= 4'(LINES_PER_LVL)) begin
                        lines_to_next_d = ltn_sum - 4'(LINES_PER_LVL);
                        if (level_q < 4'(LEVEL_MAX)) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        lines_to_next_d = ltn_sum;
                    end
                end
                busy_low_d = 1'b0;
                state_d    = ST_NOTIFY;
            end
            ST_NOTIFY: begin
                // Second consecutive idle cycle skips the converter's DONE cycle
                if (conv.conv_busy) begin
                    busy_low_d = 1'b0;
                end else if (busy_low_q) begin
                    busy_low_d   = 1'b0;
                    conv_start_d = 1'b1;
                    state_d      = ST_WAIT_ACK;
                end else begin
                    busy_low_d = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; game reset clears exactly like the pin reset
    always_ff @(posedge clk_in) begin
        if (clear) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            mult_q          <= '0;
            product_q       <= '0;
            iter_q          <= '0;
            evt_n_q         <= '0;
            pend_valid_q    <= 1'b0;
            pend_n_q        <= '0;
            drop_acc_q      <= '0;
            lines_to_next_q <= '0;
            busy_low_q      <= 1'b0;
            score_q         <= '0;
            conv_start_q    <= 1'b0;
            level_q         <= '0;
            lines_total_q   <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            mult_q          <= mult_d;
            product_q       <= product_d;
            iter_q          <= iter_d;
            evt_n_q         <= evt_n_d;
            pend_valid_q    <= pend_valid_d;
            pend_n_q        <= pend_n_d;
            drop_acc_q      <= drop_acc_d;
            lines_to_next_q <= lines_to_next_d;
            busy_low_q      <= busy_low_d;
            score_q         <= score_d;
            conv_start_q    <= conv_start_d;
            level_q         <= level_d;
            lines_total_q   <= lines_total_d;
            overflow_q      <= overflow_d;
        end
    end

    assign conv.score      = score_q;
    assign conv.conv_start = conv_start_q;
    assign level           = level_q;
    assign lines_total     = lines_total_q;
    assign lines_overflow  = overflow_q;

endmodule
